fdtd_step_ctrl: RTL and testbench

FDTD_STEP_CTRL -- requirements
Module: fdtd_step_ctrl

---
 rtl/fdtd_step_ctrl_if.sv | 60 ++++++
 rtl/fdtd_step_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fdtd_step_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdtd_step_ctrl_if.sv
// Bundles the run configuration, buffer loader, update unit and write-back
// handshakes of the FDTD timestep controller; master is the controller side.
interface fdtd_step_ctrl_if #(
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int STEP_WIDTH        = 16
);

  logic                         start_i;
  logic [BUFFER_ADDR_WIDTH:0]   cfg_cells_i;
  logic [STEP_WIDTH-1:0]        cfg_steps_i;
  logic [STEP_WIDTH-1:0]        cfg_src_steps_i;

  logic                         mem_vld_i;
  logic                         buf_hy_start_o;
  logic                         buf_ez_start_o;
  logic                         buf_src_start_o;
  logic                         buf_hy_end_o;
  logic                         buf_ez_end_o;
  logic                         buf_src_end_o;

  logic                         rd_en_o;
  logic [BUFFER_ADDR_WIDTH-1:0] rd_addr_o;
  logic                         calc_sel_o;
  logic                         calc_vld_i;
  logic                         wr_hy_en_o;
  logic                         wr_ez_en_o;
  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr_o;

  logic                         mem_rd_hy_en_o;
  logic                         mem_rd_ez_en_o;
  logic                         mem_rd_end_o;
  logic                         wb_vld_i;

  logic                         busy_o;
  logic                         done_o;
  logic [STEP_WIDTH-1:0]        step_o;

  modport master (
    input  start_i, cfg_cells_i, cfg_steps_i, cfg_src_steps_i,
    input  mem_vld_i, calc_vld_i, wb_vld_i,
    output buf_hy_start_o, buf_ez_start_o, buf_src_start_o,
    output buf_hy_end_o, buf_ez_end_o, buf_src_end_o,
    output rd_en_o, rd_addr_o, calc_sel_o,
    output wr_hy_en_o, wr_ez_en_o, wr_addr_o,
    output mem_rd_hy_en_o, mem_rd_ez_en_o, mem_rd_end_o,
    output busy_o, done_o, step_o
  );

  modport slave (
    output start_i, cfg_cells_i, cfg_steps_i, cfg_src_steps_i,
    output mem_vld_i, calc_vld_i, wb_vld_i,
    input  buf_hy_start_o, buf_ez_start_o, buf_src_start_o,
    input  buf_hy_end_o, buf_ez_end_o, buf_src_end_o,
    input  rd_en_o, rd_addr_o, calc_sel_o,
    input  wr_hy_en_o, wr_ez_en_o, wr_addr_o,
    input  mem_rd_hy_en_o, mem_rd_ez_en_o, mem_rd_end_o,
    input  busy_o, done_o, step_o
  );

endinterface

// File: rtl/fdtd_step_ctrl.sv
// FDTD timestep sequencer: per step loads Hy and Ez (or source) buffers, runs
// the Hy then Ez update passes, writes both fields back, until S steps are done.
module fdtd_step_ctrl #(
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int STEP_WIDTH        = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  fdtd_step_ctrl_if.master  bus
);

  localparam int CW = BUFFER_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_HY   = 3'd1,
    LD_EZ   = 3'd2,
    CALC_HY = 3'd3,
    CALC_EZ = 3'd4,
    WB_HY   = 3'd5,
    WB_EZ   = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [CW-1:0]         r_cells;
  logic [STEP_WIDTH-1:0] r_steps;
  logic [STEP_WIDTH-1:0] r_src_steps;
  logic [STEP_WIDTH-1:0] r_step;
  logic [CW-1:0]         r_beat;
  logic [CW-1:0]         r_rd_cnt;
  logic [CW-1:0]         r_wr_cnt;
  logic                  r_entry;

  logic [CW-1:0]         w_last;
  logic                  w_in_ld;
  logic                  w_in_wb;
  logic                  w_in_calc;
  logic                  w_ld_beat;
  logic                  w_ld_last;
  logic                  w_wb_beat;
  logic                  w_wb_last;
  logic                  w_calc_beat;
  logic                  w_calc_last;
  logic                  w_rd_active;
  logic                  w_use_src;
  logic                  w_state_change;
  logic [STEP_WIDTH-1:0] w_step_inc;

  // Counters are W+1 bits wide so a full buffer of 2^W cells never wraps.
  assign w_last         = r_cells - 1'b1;
  assign w_in_ld        = (r_state == LD_HY) || (r_state == LD_EZ);
  assign w_in_wb        = (r_state == WB_HY) || (r_state == WB_EZ);
  assign w_in_calc      = (r_state == CALC_HY) || (r_state == CALC_EZ);
  assign w_ld_beat      = w_in_ld && bus.mem_vld_i;
  assign w_ld_last      = w_ld_beat && (r_beat == w_last);
  assign w_wb_beat      = w_in_wb && bus.wb_vld_i;
  assign w_wb_last      = w_wb_beat && (r_beat == w_last);
  assign w_calc_beat    = w_in_calc && bus.calc_vld_i && (r_wr_cnt < r_cells);
  assign w_calc_last    = w_calc_beat && (r_wr_cnt == w_last);
  assign w_rd_active    = w_in_calc && (r_rd_cnt < r_cells);
  assign w_use_src      = r_step < r_src_steps;
  assign w_step_inc     = r_step + 1'b1;
  assign w_state_change = (w_next != r_state);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start_i) w_next = (bus.cfg_steps_i == '0) ? DONE : LD_HY;
      LD_HY:   if (w_ld_last) w_next = LD_EZ;
      LD_EZ:   if (w_ld_last) w_next = CALC_HY;
      CALC_HY: if (w_calc_last) w_next = CALC_EZ;
      CALC_EZ: if (w_calc_last) w_next = WB_HY;
      WB_HY:   if (w_wb_last) w_next = WB_EZ;
      WB_EZ:   if (w_wb_last) w_next = (w_step_inc == r_steps) ? DONE : LD_HY;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Every state change restarts the beat counters, so each state sees fresh counts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cells     <= '0;
      r_steps     <= '0;
      r_src_steps <= '0;
      r_step      <= '0;
      r_beat      <= '0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_entry     <= 1'b0;
    end else begin
      r_entry <= w_state_change;
      if (w_state_change) begin
        r_beat   <= '0;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_ld_beat || w_wb_beat) r_beat <= r_beat + 1'b1;
        if (w_rd_active)            r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_calc_beat)            r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if ((r_state == IDLE) && bus.start_i) begin
        r_cells     <= bus.cfg_cells_i;
        r_steps     <= bus.cfg_steps_i;
        r_src_steps <= bus.cfg_src_steps_i;
        r_step      <= '0;
      end else if ((r_state == WB_EZ) && w_wb_last && (r_step < r_steps)) begin
        r_step <= w_step_inc;
      end
    end
  end

  always_comb begin
    bus.buf_hy_start_o  = 1'b0;
    bus.buf_ez_start_o  = 1'b0;
    bus.buf_src_start_o = 1'b0;
    bus.buf_hy_end_o    = 1'b0;
    bus.buf_ez_end_o    = 1'b0;
    bus.buf_src_end_o   = 1'b0;
    bus.rd_en_o         = 1'b0;
    bus.rd_addr_o       = r_rd_cnt[BUFFER_ADDR_WIDTH-1:0];
    bus.calc_sel_o      = 1'b0;
    bus.wr_hy_en_o      = 1'b0;
    bus.wr_ez_en_o      = 1'b0;
    bus.wr_addr_o       = r_wr_cnt[BUFFER_ADDR_WIDTH-1:0];
    bus.mem_rd_hy_en_o  = 1'b0;
    bus.mem_rd_ez_en_o  = 1'b0;
    bus.mem_rd_end_o    = 1'b0;
    bus.busy_o          = (r_state != IDLE);
    bus.done_o          = 1'b0;
    bus.step_o          = r_step;
    case (r_state)
      LD_HY: begin
        bus.buf_hy_start_o = r_entry;
        bus.buf_hy_end_o   = w_ld_last;
      end
      LD_EZ: begin
        if (w_use_src) begin
          bus.buf_src_start_o = r_entry;
          bus.buf_src_end_o   = w_ld_last;
        end else begin
          bus.buf_ez_start_o = r_entry;
          bus.buf_ez_end_o   = w_ld_last;
        end
      end
      CALC_HY: begin
        bus.rd_en_o    = w_rd_active;
        bus.wr_hy_en_o = w_calc_beat;
      end
      CALC_EZ: begin
        bus.calc_sel_o = 1'b1;
        bus.rd_en_o    = w_rd_active;
        bus.wr_ez_en_o = w_calc_beat;
      end
      WB_HY: begin
        bus.mem_rd_hy_en_o = 1'b1;
        bus.mem_rd_end_o   = w_wb_last;
      end
      WB_EZ: begin
        bus.mem_rd_ez_en_o = 1'b1;
        bus.mem_rd_end_o   = w_wb_last;
      end
      DONE: begin
        bus.done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fdtd_step_ctrl.sv
// Scoreboard bench for fdtd_step_ctrl: directed runs push expected strobe
// events into per-class queues; a negedge monitor pops and compares them.
module tb_fdtd_step_ctrl;

  localparam int W  = 6;
  localparam int SW = 16;

  logic CLK = 1'b0;
  logic RST_N;

  fdtd_step_ctrl_if #(.BUFFER_ADDR_WIDTH(W), .STEP_WIDTH(SW)) bus ();

  fdtd_step_ctrl #(.BUFFER_ADDR_WIDTH(W), .STEP_WIDTH(SW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Event codes: buf 0/1/2 = hy/ez/src start, +4 = end; rd/wr = 256*sel + addr.
  logic [15:0] qBuf[$];
  logic [15:0] qRd[$];
  logic [15:0] qWr[$];
  logic [15:0] qWb[$];
  logic [15:0] qDone[$];

  int compareCount  = 0;
  int mismatchCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic popCompare(input string name, input int cls, input logic [15:0] act);
    logic [15:0] exp;
    bit empty;
    empty = 1'b0;
    exp   = '0;
    case (cls)
      0: if (qBuf.size() == 0)  empty = 1'b1; else exp = qBuf.pop_front();
      1: if (qRd.size() == 0)   empty = 1'b1; else exp = qRd.pop_front();
      2: if (qWr.size() == 0)   empty = 1'b1; else exp = qWr.pop_front();
      3: if (qWb.size() == 0)   empty = 1'b1; else exp = qWb.pop_front();
      default: if (qDone.size() == 0) empty = 1'b1; else exp = qDone.pop_front();
    endcase
    compareCount++;
    if (empty) begin
      mismatchCount++;
      $display("[TB] FAIL %s: unexpected event actual=%0d required=no event", name, act);
    end else if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    int nStart;
    int nEnd;
    if (RST_N) begin
      nStart = int'(bus.buf_hy_start_o) + int'(bus.buf_ez_start_o) + int'(bus.buf_src_start_o);
      nEnd   = int'(bus.buf_hy_end_o) + int'(bus.buf_ez_end_o) + int'(bus.buf_src_end_o);
      if (nStart > 0) checkOutput("oneStart", 32'(nStart <= 1), 1);
      if (nEnd > 0)   checkOutput("oneEnd", 32'(nEnd <= 1), 1);
      if (bus.buf_hy_start_o)  popCompare("buf", 0, 16'd0);
      if (bus.buf_ez_start_o)  popCompare("buf", 0, 16'd1);
      if (bus.buf_src_start_o) popCompare("buf", 0, 16'd2);
      if (bus.buf_hy_end_o)    popCompare("buf", 0, 16'd4);
      if (bus.buf_ez_end_o)    popCompare("buf", 0, 16'd5);
      if (bus.buf_src_end_o)   popCompare("buf", 0, 16'd6);
      if (bus.rd_en_o)    popCompare("rd", 1, {7'd0, bus.calc_sel_o, 2'd0, bus.rd_addr_o});
      if (bus.wr_hy_en_o) popCompare("wr", 2, {10'd0, bus.wr_addr_o});
      if (bus.wr_ez_en_o) popCompare("wr", 2, {7'd0, 1'b1, 2'd0, bus.wr_addr_o});
      if (bus.mem_rd_end_o) popCompare("wbEnd", 3, {15'd0, bus.mem_rd_ez_en_o});
      if (bus.done_o)     popCompare("done", 4, bus.step_o);
    end
  end

  task automatic pushStep(input int n, input bit useSrc, input bit withWb);
    qBuf.push_back(16'd0);
    qBuf.push_back(16'd4);
    qBuf.push_back(useSrc ? 16'd2 : 16'd1);
    qBuf.push_back(useSrc ? 16'd6 : 16'd5);
    for (int sel = 0; sel < 2; sel++) begin
      for (int a = 0; a < n; a++) begin
        qRd.push_back(16'(256 * sel + a));
        qWr.push_back(16'(256 * sel + a));
      end
    end
    if (withWb) begin
      qWb.push_back(16'd0);
      qWb.push_back(16'd1);
    end
  endtask

  task automatic applyStimulus(input int cells, input int steps, input int srcSteps);
    @(posedge CLK); #1;
    bus.cfg_cells_i     = (W+1)'(cells);
    bus.cfg_steps_i     = SW'(steps);
    bus.cfg_src_steps_i = SW'(srcSteps);
    bus.start_i         = 1'b1;
    @(posedge CLK); #1;
    bus.start_i         = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (bus.done_o) break;
      @(posedge CLK); #1;
    end
    if (i == budget) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL doneTimeout: actual=no done required=done within %0d cycles", budget);
    end
  endtask

  task automatic waitUntil(input string name, input int sel, input int budget);
    int i;
    bit hit;
    hit = 1'b0;
    for (i = 0; i < budget && !hit; i++) begin
      @(posedge CLK); #1;
      case (sel)
        0: hit = bus.rd_en_o && !bus.calc_sel_o;
        1: hit = bus.calc_sel_o;
        default: hit = bus.mem_rd_hy_en_o;
      endcase
    end
    if (!hit) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL %s: actual=not reached required=reached within %0d cycles", name, budget);
    end
  endtask

  task automatic finishRun(input string name, input int expStep);
    @(posedge CLK); #1;
    checkOutput({name, "Busy"}, 32'(bus.busy_o), 0);
    checkOutput({name, "DoneLow"}, 32'(bus.done_o), 0);
    checkOutput({name, "Step"}, 32'(bus.step_o), expStep);
    checkOutput({name, "BufLeft"}, qBuf.size(), 0);
    checkOutput({name, "RdLeft"}, qRd.size(), 0);
    checkOutput({name, "WrLeft"}, qWr.size(), 0);
    checkOutput({name, "WbLeft"}, qWb.size(), 0);
    checkOutput({name, "DoneLeft"}, qDone.size(), 0);
  endtask

  task automatic checkAllQuiet(input string name);
    checkOutput({name, "Busy"}, 32'(bus.busy_o), 0);
    checkOutput({name, "Done"}, 32'(bus.done_o), 0);
    checkOutput({name, "Step"}, 32'(bus.step_o), 0);
    checkOutput({name, "RdEn"}, 32'(bus.rd_en_o), 0);
    checkOutput({name, "WrEn"}, 32'({bus.wr_hy_en_o, bus.wr_ez_en_o}), 0);
    checkOutput({name, "MemRd"}, 32'({bus.mem_rd_hy_en_o, bus.mem_rd_ez_en_o, bus.mem_rd_end_o}), 0);
    checkOutput({name, "BufStrobes"}, 32'({bus.buf_hy_start_o, bus.buf_ez_start_o, bus.buf_src_start_o,
                                           bus.buf_hy_end_o, bus.buf_ez_end_o, bus.buf_src_end_o}), 0);
  endtask

  initial begin
    logic [5:0] gapPat;
    gapPat = 6'b101001;
    RST_N               = 1'b0;
    bus.start_i         = 1'b0;
    bus.cfg_cells_i     = '0;
    bus.cfg_steps_i     = '0;
    bus.cfg_src_steps_i = '0;
    bus.mem_vld_i       = 1'b1;
    bus.calc_vld_i      = 1'b1;
    bus.wb_vld_i        = 1'b1;
    #1;
    checkAllQuiet("reset");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    $display("[TB] run 1: N=4 S=1 src=0");
    pushStep(4, 1'b0, 1'b1);
    qDone.push_back(16'd1);
    applyStimulus(4, 1, 0);
    waitDone(200);
    finishRun("run1", 1);

    $display("[TB] run 2: N=64 S=2 src=1");
    pushStep(64, 1'b1, 1'b1);
    pushStep(64, 1'b0, 1'b1);
    qDone.push_back(16'd2);
    applyStimulus(64, 2, 1);
    waitDone(2000);
    finishRun("run2", 2);

    $display("[TB] run 3: N=3 gapped calc valid");
    bus.calc_vld_i = 1'b0;
    pushStep(3, 1'b1, 1'b1);
    qDone.push_back(16'd1);
    applyStimulus(3, 1, 1);
    waitUntil("reachCalcHy", 0, 100);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      bus.calc_vld_i = gapPat[5-i];
    end
    checkOutput("gapSelBeforeLast", 32'(bus.calc_sel_o), 0);
    checkOutput("gapLastAddr", 32'(bus.wr_addr_o), 2);
    @(posedge CLK); #1;
    checkOutput("gapSelAfterLast", 32'(bus.calc_sel_o), 1);
    bus.calc_vld_i = 1'b1;
    waitDone(200);
    finishRun("run3", 1);

    $display("[TB] run 4: S=0");
    qDone.push_back(16'd0);
    applyStimulus(5, 0, 0);
    checkOutput("s0DoneNow", 32'(bus.done_o), 1);
    waitDone(5);
    finishRun("run4", 0);

    $display("[TB] run 5: reset in WB_HY");
    pushStep(4, 1'b0, 1'b0);
    applyStimulus(4, 1, 0);
    waitUntil("reachWbHy", 2, 200);
    repeat (2) begin
      @(posedge CLK); #1;
    end
    RST_N = 1'b0;
    #1;
    checkAllQuiet("midReset");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("noResumeBusy", 32'(bus.busy_o), 0);
    pushStep(2, 1'b0, 1'b1);
    qDone.push_back(16'd1);
    applyStimulus(2, 1, 0);
    checkOutput("restartHyStart", 32'(bus.buf_hy_start_o), 1);
    checkOutput("restartStep", 32'(bus.step_o), 0);
    waitDone(100);
    finishRun("run5", 1);

    $display("[TB] run 6: start during CALC_EZ");
    pushStep(4, 1'b0, 1'b1);
    pushStep(4, 1'b0, 1'b1);
    qDone.push_back(16'd2);
    applyStimulus(4, 2, 0);
    waitUntil("reachCalcEz", 1, 100);
    bus.cfg_cells_i = 7'd2;
    bus.cfg_steps_i = 16'd1;
    bus.start_i     = 1'b1;
    @(posedge CLK); #1;
    bus.start_i     = 1'b0;
    waitDone(300);
    finishRun("run6", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
